// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: stall vectors, stop levels, MEM FSM states.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; a stalled stage freezes everything upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/pipe_ctrl_memwait.sv
// MEM-stage wait handshake: stall from start until the done pulse; zero-cycle stall when done coincides with start.
// Latency: mem_stall is combinational on the inputs; state advances on the next clk edge.
module pipe_ctrl_memwait
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mem_start,
    input  logic mem_done,
    output logic mem_stall
);

    mem_state_t state;
    mem_state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= M_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A done pulse seen in M_IDLE without a start is stale and ignored.
    always_comb begin
        state_nxt = state;
        mem_stall = NO_STOP;
        unique case (state)
            M_IDLE: begin
                if (mem_start && !mem_done) begin
                    state_nxt = M_WAIT;
                    mem_stall = STOP;
                end
            end
            M_WAIT: begin
                if (mem_done) begin
                    state_nxt = M_IDLE;
                end else begin
                    mem_stall = STOP;
                end
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: prioritised stall vector, branch flush/redirect, load-use bubble counter.
// Outputs are combinational on requests; optional perf counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_busy_i,
    input  logic              id_lu_i,
    input  logic              ex_busy_i,
    input  logic              mem_start_i,
    input  logic              mem_done_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_cnt_o
);

    logic             mem_stall;
    logic             ex_stall;
    logic             id_stall;
    logic             if_stall;
    logic             higher_stall;
    logic             accept;
    logic [CNT_W-1:0] lu_cnt;

    pipe_ctrl_memwait u_memwait (
        .clk       (clk),
        .rst       (rst),
        .mem_start (mem_start_i),
        .mem_done  (mem_done_i),
        .mem_stall (mem_stall)
    );

    assign ex_stall     = ex_busy_i;
    assign if_stall     = if_busy_i;
    assign id_stall     = id_lu_i | (lu_cnt != '0);
    assign higher_stall = ex_stall | mem_stall;

    // Outputs are forced quiet while rst is held, even with requests asserted.
    always_comb begin
        stall_o = STALL_NONE;
        if (!rst) begin
            if (mem_stall) begin
                stall_o = STALL_MEM;
            end else if (ex_stall) begin
                stall_o = STALL_EX;
            end else if (id_stall) begin
                stall_o = STALL_ID;
            end else if (if_stall) begin
                stall_o = STALL_IF;
            end
        end
    end

    // A branch while EX is held is deferred; EX keeps presenting it.
    assign accept        = branch_i & ~stall_o[3] & ~rst;
    assign flush_o       = accept;
    assign redirect_o    = accept;
    assign redirect_pc_o = accept ? branch_target_i : '0;

    // Squashed load-use bubbles are dropped on accept; a load-use seen under a
    // higher stall is not latched because ID re-asserts it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt <= '0;
        end else if (accept) begin
            lu_cnt <= '0;
        end else if (higher_stall) begin
            lu_cnt <= lu_cnt;
        end else if (id_lu_i) begin
            lu_cnt <= CNT_W'(LU_BUBBLES - 1);
        end else if (lu_cnt != '0) begin
            lu_cnt <= lu_cnt - CNT_W'(1);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= ZERO_WORD;
            flush_cnt_q    <= ZERO_WORD;
        end else begin
            if (stall_o != STALL_NONE) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (accept) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cnt_o    = flush_cnt_q;
`else
    assign stall_cycles_o = ZERO_WORD;
    assign flush_cnt_o    = ZERO_WORD;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, hand-written multi-cycle sequences, randomized run vs reference model.
module tb_pipe_ctrl;

    localparam int LU = 2;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_busy_i, id_lu_i, ex_busy_i, mem_start_i, mem_done_i, branch_i;
    logic [31:0] branch_target_i;
    logic [5:0]  stall_o;
    logic        flush_o, redirect_o;
    logic [31:0] redirect_pc_o, stall_cycles_o, flush_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(32), .LU_BUBBLES(LU), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_busy_i       (if_busy_i),
        .id_lu_i         (id_lu_i),
        .ex_busy_i       (ex_busy_i),
        .mem_start_i     (mem_start_i),
        .mem_done_i      (mem_done_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .stall_cycles_o  (stall_cycles_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    typedef struct {
        logic        r, ifb, lu, exb, ms, md, br;
        logic [31:0] tgt;
    } in_t;

    typedef struct {
        logic [5:0]  st;
        logic        fl;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state (abstract: waiting flag, bubbles left, event counts)
    bit          m_wait;
    int          m_rem;
    int unsigned m_scnt, m_fcnt;

    function automatic in_t mk(logic r, logic ifb, logic lu, logic exb, logic ms, logic md,
                               logic br, logic [31:0] tgt);
        in_t x;
        x.r = r; x.ifb = ifb; x.lu = lu; x.exb = exb; x.ms = ms; x.md = md; x.br = br; x.tgt = tgt;
        return x;
    endfunction

    function automatic exp_t mke(logic [5:0] st, logic fl, logic [31:0] rpc);
        exp_t x;
        x.st = st; x.fl = fl; x.rpc = rpc;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
    task automatic step(input in_t i, input exp_t e, input string name);
        rst = i.r; if_busy_i = i.ifb; id_lu_i = i.lu; ex_busy_i = i.exb;
        mem_start_i = i.ms; mem_done_i = i.md; branch_i = i.br; branch_target_i = i.tgt;
        @(negedge clk);
        check($sformatf("%s stall", name), 32'(stall_o), 32'(e.st));
        check($sformatf("%s flush", name), 32'(flush_o), 32'(e.fl));
        check($sformatf("%s redirect", name), 32'(redirect_o), 32'(e.fl));
        check($sformatf("%s redirect_pc", name), redirect_pc_o, e.rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name);
        step(mk(0,0,0,0,0,0,0,32'h0), mke(6'b000000, 0, 32'h0), name);
    endtask

    task automatic do_reset(input string name);
        step(mk(1,0,0,0,0,0,0,32'h0), mke(6'b000000, 0, 32'h0), name);
    endtask

    vec_t vt[15];

    initial begin
        in_t  ri;
        exp_t re;
        bit   mem_s, hi, acc;

        rst = 1'b1; if_busy_i = 0; id_lu_i = 0; ex_busy_i = 0; mem_start_i = 0;
        mem_done_i = 0; branch_i = 0; branch_target_i = 32'h0;
        #1;

        // Each vector is applied from a freshly reset state (M_IDLE, no bubbles pending).
        //           r ifb lu exb ms md br  tgt              st         fl  rpc
        vt[0]  = '{mk(0,0,0,0,0,0,0,32'h0000_0000), mke(6'b000000, 0, 32'h0)};
        vt[1]  = '{mk(0,1,0,0,0,0,0,32'h0000_0000), mke(6'b000011, 0, 32'h0)};
        vt[2]  = '{mk(0,0,1,0,0,0,0,32'h0000_0000), mke(6'b000111, 0, 32'h0)};
        vt[3]  = '{mk(0,0,0,1,0,0,0,32'h0000_0000), mke(6'b001111, 0, 32'h0)};
        vt[4]  = '{mk(0,0,0,0,1,0,0,32'h0000_0000), mke(6'b011111, 0, 32'h0)};
        vt[5]  = '{mk(0,0,0,0,1,1,0,32'h0000_0000), mke(6'b000000, 0, 32'h0)};
        vt[6]  = '{mk(0,0,0,0,0,1,0,32'h0000_0000), mke(6'b000000, 0, 32'h0)};
        vt[7]  = '{mk(0,1,1,0,0,0,0,32'h0000_0000), mke(6'b000111, 0, 32'h0)};
        vt[8]  = '{mk(0,0,0,1,1,0,0,32'h0000_0000), mke(6'b011111, 0, 32'h0)};
        vt[9]  = '{mk(0,0,0,0,0,0,1,32'h0000_1000), mke(6'b000000, 1, 32'h0000_1000)};
        vt[10] = '{mk(0,1,0,0,0,0,1,32'hDEAD_BEE0), mke(6'b000011, 1, 32'hDEAD_BEE0)};
        vt[11] = '{mk(0,0,1,0,0,0,1,32'h0000_2004), mke(6'b000111, 1, 32'h0000_2004)};
        vt[12] = '{mk(0,0,0,1,0,0,1,32'h0000_3000), mke(6'b001111, 0, 32'h0)};
        vt[13] = '{mk(0,0,0,0,1,0,1,32'h0000_4000), mke(6'b011111, 0, 32'h0)};
        vt[14] = '{mk(0,0,0,0,1,1,1,32'h8000_0000), mke(6'b000000, 1, 32'h8000_0000)};

        for (int k = 0; k < 15; k++) begin
            do_reset($sformatf("vec%0d_rst", k));
            step(vt[k].i, vt[k].e, $sformatf("vec%0d", k));
        end

        // Reset held two cycles with every request high, then released.
        step(mk(1,1,1,1,1,0,1,32'h1000), mke(6'b000000, 0, 32'h0), "rst_hold0");
        step(mk(1,1,1,1,1,0,1,32'h1000), mke(6'b000000, 0, 32'h0), "rst_hold1");
        step(mk(0,1,0,1,1,0,1,32'h1000), mke(6'b011111, 0, 32'h0), "rst_release");

        // MEM wait: start at c0, done pulse at c3, back to idle at c4.
        do_reset("mem_rst");
        step(mk(0,0,0,0,1,0,0,32'h0), mke(6'b011111, 0, 32'h0), "mem_c0");
        step(mk(0,0,0,0,1,0,0,32'h0), mke(6'b011111, 0, 32'h0), "mem_c1");
        step(mk(0,0,0,0,1,0,0,32'h0), mke(6'b011111, 0, 32'h0), "mem_c2");
        step(mk(0,0,0,0,1,1,0,32'h0), mke(6'b000000, 0, 32'h0), "mem_c3");
        idle("mem_c4_idle");

        // Load-use with two bubbles.
        do_reset("lu_rst");
        step(mk(0,0,1,0,0,0,0,32'h0), mke(6'b000111, 0, 32'h0), "lu_c0");
        step(mk(0,0,0,0,0,0,0,32'h0), mke(6'b000111, 0, 32'h0), "lu_c1");
        idle("lu_c2");

        // Load-use under EX stall is dropped; ID re-asserts once EX frees.
        do_reset("luex_rst");
        step(mk(0,0,1,1,0,0,0,32'h0), mke(6'b001111, 0, 32'h0), "luex_c0");
        step(mk(0,0,0,1,0,0,0,32'h0), mke(6'b001111, 0, 32'h0), "luex_c1");
        step(mk(0,0,0,1,0,0,0,32'h0), mke(6'b001111, 0, 32'h0), "luex_c2");
        step(mk(0,0,1,0,0,0,0,32'h0), mke(6'b000111, 0, 32'h0), "luex_c3");
        step(mk(0,0,0,0,0,0,0,32'h0), mke(6'b000111, 0, 32'h0), "luex_c4");
        idle("luex_c5");

        // Branch deferred under MEM wait, accepted in the done cycle.
        do_reset("brm_rst");
        step(mk(0,0,0,0,1,0,1,32'h1000), mke(6'b011111, 0, 32'h0), "brm_c0");
        step(mk(0,0,0,0,1,0,1,32'h1000), mke(6'b011111, 0, 32'h0), "brm_c1");
        step(mk(0,0,0,0,1,1,1,32'h1000), mke(6'b000000, 1, 32'h1000), "brm_c2");
        idle("brm_c3");

        // Accepted branch squashes the pending load-use bubbles.
        do_reset("brlu_rst");
        step(mk(0,0,1,0,0,0,1,32'h0000_0040), mke(6'b000111, 1, 32'h0000_0040), "brlu_c0");
        idle("brlu_c1");

        // Reset mid-wait abandons the MEM wait.
        do_reset("rstm_rst");
        step(mk(0,0,0,0,1,0,0,32'h0), mke(6'b011111, 0, 32'h0), "rstm_c0");
        step(mk(1,0,0,0,1,0,0,32'h0), mke(6'b000000, 0, 32'h0), "rstm_c1");
        idle("rstm_c2");

        // Performance counters: three stall cycles and one accepted branch.
        do_reset("perf_rst");
        step(mk(0,1,0,0,0,0,0,32'h0), mke(6'b000011, 0, 32'h0), "perf_c0");
        step(mk(0,1,0,0,0,0,0,32'h0), mke(6'b000011, 0, 32'h0), "perf_c1");
        step(mk(0,1,0,0,0,0,0,32'h0), mke(6'b000011, 0, 32'h0), "perf_c2");
        step(mk(0,0,0,0,0,0,1,32'h2000), mke(6'b000000, 1, 32'h2000), "perf_c3");
        idle("perf_c4");
        check("perf stall_cycles", stall_cycles_o, PERF_ON ? 32'd3 : 32'd0);
        check("perf flush_cnt", flush_cnt_o, PERF_ON ? 32'd1 : 32'd0);

        // Randomized run against the reference model.
        do_reset("rand_rst");
        m_wait = 0; m_rem = 0; m_scnt = 0; m_fcnt = 0;
        for (int n = 0; n < 400; n++) begin
            ri = mk($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom);
            mem_s = (m_wait || ri.ms) && !ri.md;
            hi    = mem_s || ri.exb;
            acc   = ri.br && !hi;
            if (ri.r) begin
                re = mke(6'b000000, 0, 32'h0);
            end else begin
                if (mem_s)                    re.st = 6'b011111;
                else if (ri.exb)              re.st = 6'b001111;
                else if (ri.lu || m_rem > 0)  re.st = 6'b000111;
                else if (ri.ifb)              re.st = 6'b000011;
                else                          re.st = 6'b000000;
                re.fl  = acc;
                re.rpc = acc ? ri.tgt : 32'h0;
            end
            step(ri, re, $sformatf("rand%0d", n));
            if (ri.r) begin
                m_wait = 0; m_rem = 0; m_scnt = 0; m_fcnt = 0;
            end else begin
                m_wait = mem_s;
                if (acc)             m_rem = 0;
                else if (hi)         m_rem = m_rem;
                else if (ri.lu)      m_rem = LU - 1;
                else if (m_rem > 0)  m_rem = m_rem - 1;
                if (re.st != 6'b0) m_scnt++;
                if (acc)           m_fcnt++;
            end
            check($sformatf("rand%0d stall_cycles", n), stall_cycles_o, PERF_ON ? m_scnt : 32'd0);
            check($sformatf("rand%0d flush_cnt", n), flush_cnt_o, PERF_ON ? m_fcnt : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline: PC, IF, IF/ID, ID/EX, EX/MEM, MEM/WB. Collects stall requests from IF, ID (load-use), EX (multi-cycle ALU) and MEM (multi-cycle memory access). Resolves them into a prioritised stall[5:0] vector and a branch flush/redirect. Owns the MEM-wait handshake FSM and the load-use bubble counter.

Parameters:
- ADDR_W, 32, PC/target width
- LU_BUBBLES, 1, bubbles inserted per load-use request (legal 1..15)
- CNT_W, 4, width of bubble counter

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_busy_i  in  1  IF fetch not complete (level)
- id_lu_i  in  1  load-use hazard detected in ID (1-cycle pulse)
- ex_busy_i  in  1  EX multi-cycle op in progress (level)
- mem_start_i  in  1  MEM-stage instruction needs memory access (level until done)
- mem_done_i  in  1  memory controller completion (1-cycle pulse)
- branch_i  in  1  EX resolved taken branch/jump
- branch_target_i  in  ADDR_W  redirect target
- stall_o  out  6  stall vector; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop
- flush_o  out  1  branch flush to IF/ID and ID/EX
- redirect_o  out  1  PC load strobe
- redirect_pc_o  out  ADDR_W  PC load value
- stall_cycles_o  out  32  perf counter (see Optional Feature)
- flush_cnt_o  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high rst on clk): mem_state=M_IDLE, lu_cnt=0. Outputs: stall_o=0, flush_o=0, redirect_o=0, redirect_pc_o=0, counters=0. Reset mid-stall abandons the MEM wait and bubble count immediately.
- MEM FSM, two states:
  - M_IDLE -> M_WAIT when mem_start_i & ~mem_done_i.
  - M_WAIT -> M_IDLE on mem_done_i.
  - mem_stall = (M_IDLE & mem_start_i & ~mem_done_i) | (M_WAIT & ~mem_done_i).
  - mem_done_i in the same cycle as mem_start_i gives zero stall.
  - mem_done_i in M_IDLE without start is ignored.
- Load-use counter:
  - id_stall = id_lu_i | (lu_cnt != 0).
  - On id_lu_i with no higher stall: lu_cnt <= LU_BUBBLES-1.
  - Otherwise, if lu_cnt != 0 and no higher stall: decrement.
  - While ex_stall or mem_stall is active, lu_cnt holds.
  - id_lu_i during a higher stall loads the counter once the higher stall clears; the ID stage re-asserts it.
- ex_stall = ex_busy_i; if_stall = if_busy_i.
- Priority, combinational stall_o, highest stage wins:
  - mem_stall: 011111
  - ex_stall: 001111
  - id_stall: 000111
  - if_stall: 000011
  - none: 000000
  - The lower stage is stalled and the next stage gets a bubble.
- Branch acceptance: accept = branch_i & ~stall_o[3]; a branch while EX is held is deferred, since EX re-presents branch_i each cycle.
  - flush_o = accept (combinational, same cycle).
  - redirect_o = accept; redirect_pc_o = branch_target_i when accept, else 0.
  - accept clears lu_cnt to 0 next edge; the squashed load-use does not re-stall.
  - flush_o has priority over stall_o[1:2] in downstream pipeline registers; pipe_ctrl still drives stall_o unchanged.
- Latency: stall_o reacts in the same cycle as its request; the internal state (FSM, counter) updates at the next posedge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined:
  - stall_cycles_o increments every cycle stall_o != 0.
  - flush_cnt_o increments on each accept.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and are cleared by rst.
- When undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package/defines:
  - stall vector constants STALL_NONE/IF/ID/EX/MEM.
  - Stop/NoStop encodings.
  - mem_state encoding M_IDLE/M_WAIT.
  - ZeroWord.
- One sub-module, pipe_ctrl_memwait (MEM FSM, outputs mem_stall). The counter and priority logic stay in the top.

Test Plan:
- Reset held 2 cycles with all requests high -> stall_o=000000, redirect_o=0 during reset. First cycle after release -> stall_o=011111.
- mem_start_i=1 at cycle 0, mem_done_i pulse at cycle 3 -> stall_o=011111 in cycles 0-2, 000000 at cycle 3; FSM back to M_IDLE at cycle 4.
- LU_BUBBLES=2, id_lu_i pulse at cycle 5 -> stall_o=000111 in cycles 5-6, 000000 at cycle 7.
- id_lu_i at cycle 5 while ex_busy_i is high for cycles 5-7 (ID re-asserts id_lu_i at cycle 8) -> 001111 in cycles 5-7, then 000111 in cycles 8-9 with LU_BUBBLES=2.
- branch_i=1, target 0x0000_1000, no stall -> flush_o=1, redirect_o=1, redirect_pc_o=0x1000 same cycle. With mem_stall active -> flush_o=0 until the stall clears.
- PIPE_CTRL_PERF_EN defined: 3 stall cycles plus 1 accepted branch -> stall_cycles_o=3, flush_cnt_o=1. Undefined -> both read 0.
